// File: rtl/mod_codec_config_seq.sv
// WM8731 power-up configuration sequencer: walks a register table and issues one I2C write per entry.
// Optional build macro CODEC_CFG_RETRY_EN retries a failed entry up to MAX_RETRIES times before erroring.
module mod_codec_config_seq #(
    parameter logic [6:0] I2C_DEVICE_ADDR = 7'h1A,
    parameter int         RST_HOLD_CYCLES = 4,
    parameter int         TIMEOUT_CYCLES  = 200_000,
    parameter int         GAP_CYCLES      = 64,
    parameter int         MAX_RETRIES     = 3
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_config_done,
    output logic       o_error,
    output logic [3:0] o_error_index,
    output logic [3:0] o_error_code,
    output logic       o_i2c_nrst,
    output logic [6:0] o_i2c_addr,
    output logic [6:0] o_i2c_register,
    output logic [8:0] o_i2c_data,
    output logic       o_i2c_read_not_write,
    input  logic       i_i2c_done,
    input  logic [3:0] i_i2c_fault_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_HOLD, S_WAIT, S_GAP, S_FAIL, S_DONE, S_ERROR
    } state_t;

    localparam logic [3:0]  LAST_INDEX = 4'd10;
    localparam logic [19:0] HOLD_LOAD  = 20'(RST_HOLD_CYCLES - 1);
    localparam logic [19:0] GAP_LOAD   = 20'(GAP_CYCLES - 1);
    localparam logic [19:0] TMO_LAST   = 20'(TIMEOUT_CYCLES - 1);

    state_t      state, next_state;
    logic        done_s1, done_s2;
    logic [3:0]  fault_s1, fault_s2, fault_prev;
    logic        fault_ok;
    logic        auto_start, start_req, retry_ok;
    logic [3:0]  index;
    logic [19:0] cnt, tmo_cnt;
    logic        gap_retry;
    logic [15:0] entry;

    // {register[6:0], data[8:0]}; index 10 activates the codec last
    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    table_entry = {7'd15, 9'h000};
            4'd1:    table_entry = {7'd0,  9'h017};
            4'd2:    table_entry = {7'd1,  9'h017};
            4'd3:    table_entry = {7'd2,  9'h079};
            4'd4:    table_entry = {7'd3,  9'h079};
            4'd5:    table_entry = {7'd4,  9'h012};
            4'd6:    table_entry = {7'd5,  9'h000};
            4'd7:    table_entry = {7'd6,  9'h000};
            4'd8:    table_entry = {7'd7,  9'h00A};
            4'd9:    table_entry = {7'd8,  9'h000};
            default: table_entry = {7'd9,  9'h001};
        endcase
    endfunction

    assign entry                = table_entry(index);
    assign o_i2c_addr           = I2C_DEVICE_ADDR;
    assign o_i2c_read_not_write = 1'b0;
    assign start_req            = i_start | auto_start;
    // 4'hF is what the master shows while idle/reset, so it never counts as a fault
    assign fault_ok = (fault_s2 != 4'h0) && (fault_s2 != 4'hF) && (fault_s2 == fault_prev);

`ifdef CODEC_CFG_RETRY_EN
    logic [3:0] retries;
    assign retry_ok = (retries < 4'(MAX_RETRIES));
`else
    assign retry_ok = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start_req) next_state = S_LOAD;
            S_LOAD:  next_state = S_HOLD;
            S_HOLD:  if (cnt == 20'd0) next_state = S_WAIT;
            S_WAIT: begin
                if (fault_ok)                next_state = S_FAIL;
                else if (done_s2)            next_state = S_GAP;
                else if (tmo_cnt == TMO_LAST) next_state = S_FAIL;
            end
            S_GAP: begin
                if (cnt == 20'd0) begin
                    if (!gap_retry && index == LAST_INDEX) next_state = S_DONE;
                    else                                   next_state = S_LOAD;
                end
            end
            S_FAIL:  next_state = retry_ok ? S_GAP : S_ERROR;
            S_DONE:  next_state = S_IDLE;
            S_ERROR: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state      <= S_IDLE;
            o_i2c_nrst <= 1'b0;
        end else begin
            state      <= next_state;
            o_i2c_nrst <= (next_state == S_WAIT);
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            done_s1        <= 1'b0;
            done_s2        <= 1'b0;
            fault_s1       <= 4'h0;
            fault_s2       <= 4'h0;
            fault_prev     <= 4'h0;
            auto_start     <= 1'b1;
            index          <= 4'd0;
            cnt            <= 20'd0;
            tmo_cnt        <= 20'd0;
            gap_retry      <= 1'b0;
            o_busy         <= 1'b0;
            o_config_done  <= 1'b0;
            o_error        <= 1'b0;
            o_error_index  <= 4'd0;
            o_error_code   <= 4'd0;
            o_i2c_register <= 7'd0;
            o_i2c_data     <= 9'd0;
`ifdef CODEC_CFG_RETRY_EN
            retries        <= 4'd0;
`endif
        end else begin
            done_s1    <= i_i2c_done;
            done_s2    <= done_s1;
            fault_s1   <= i_i2c_fault_code;
            fault_s2   <= fault_s1;
            fault_prev <= fault_s2;
            auto_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (next_state == S_LOAD) begin
                        index         <= 4'd0;
                        gap_retry     <= 1'b0;
                        o_busy        <= 1'b1;
                        o_config_done <= 1'b0;
                        o_error       <= 1'b0;
                        o_error_index <= 4'd0;
                        o_error_code  <= 4'd0;
`ifdef CODEC_CFG_RETRY_EN
                        retries       <= 4'd0;
`endif
                    end
                end
                S_LOAD: begin
                    o_i2c_register <= entry[15:9];
                    o_i2c_data     <= entry[8:0];
                    cnt            <= HOLD_LOAD;
                end
                S_HOLD: begin
                    if (cnt != 20'd0) cnt <= cnt - 20'd1;
                    tmo_cnt <= 20'd0;
                end
                S_WAIT: begin
                    if (tmo_cnt != 20'hFFFFF) tmo_cnt <= tmo_cnt + 20'd1;
                    if (next_state == S_FAIL) begin
                        o_error_index <= index;
                        o_error_code  <= fault_ok ? fault_s2 : 4'hE;
                    end else if (next_state == S_GAP) begin
                        cnt       <= GAP_LOAD;
                        gap_retry <= 1'b0;
                    end
                end
                S_FAIL: begin
                    cnt       <= GAP_LOAD;
                    gap_retry <= 1'b1;
`ifdef CODEC_CFG_RETRY_EN
                    if (retry_ok) retries <= retries + 4'd1;
`endif
                end
                S_GAP: begin
                    if (cnt != 20'd0) begin
                        cnt <= cnt - 20'd1;
                    end else if (!gap_retry && index != LAST_INDEX) begin
                        index <= index + 4'd1;
`ifdef CODEC_CFG_RETRY_EN
                        retries <= 4'd0;
`endif
                    end
                end
                S_DONE: begin
                    o_busy        <= 1'b0;
                    o_config_done <= 1'b1;
                end
                S_ERROR: begin
                    o_busy  <= 1'b0;
                    o_error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_codec_config_seq.sv
// Bench for mod_codec_config_seq: behavioural I2C master, transaction scoreboard, scenario table.
module tb_mod_codec_config_seq;

    logic       clk = 1'b0;
    logic       i_nrst, i_start;
    logic       o_busy, o_config_done, o_error;
    logic [3:0] o_error_index, o_error_code;
    logic       o_i2c_nrst, o_i2c_read_not_write;
    logic [6:0] o_i2c_addr, o_i2c_register;
    logic [8:0] o_i2c_data;
    logic       i2c_done = 1'b0;
    logic [3:0] i2c_fault = 4'h0;

    always #5 clk = ~clk;

    mod_codec_config_seq #(.TIMEOUT_CYCLES(1000)) dut (
        .i_clk(clk), .i_nrst(i_nrst), .i_start(i_start),
        .o_busy(o_busy), .o_config_done(o_config_done), .o_error(o_error),
        .o_error_index(o_error_index), .o_error_code(o_error_code),
        .o_i2c_nrst(o_i2c_nrst), .o_i2c_addr(o_i2c_addr),
        .o_i2c_register(o_i2c_register), .o_i2c_data(o_i2c_data),
        .o_i2c_read_not_write(o_i2c_read_not_write),
        .i_i2c_done(i2c_done), .i_i2c_fault_code(i2c_fault)
    );

`ifdef CODEC_CFG_RETRY_EN
    localparam bit RETRY = 1'b1;
    localparam int MAXR  = 3;
`else
    localparam bit RETRY = 1'b0;
    localparam int MAXR  = 0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct { logic [6:0] rg; logic [8:0] dat; } txn_t;
    txn_t sb_q[$];

    function automatic txn_t spec_entry(input int i);
        txn_t t;
        case (i)
            0: begin t.rg = 7'd15; t.dat = 9'h000; end
            1: begin t.rg = 7'd0;  t.dat = 9'h017; end
            2: begin t.rg = 7'd1;  t.dat = 9'h017; end
            3: begin t.rg = 7'd2;  t.dat = 9'h079; end
            4: begin t.rg = 7'd3;  t.dat = 9'h079; end
            5: begin t.rg = 7'd4;  t.dat = 9'h012; end
            6: begin t.rg = 7'd5;  t.dat = 9'h000; end
            7: begin t.rg = 7'd6;  t.dat = 9'h000; end
            8: begin t.rg = 7'd7;  t.dat = 9'h00A; end
            9: begin t.rg = 7'd8;  t.dat = 9'h000; end
            default: begin t.rg = 7'd9; t.dat = 9'h001; end
        endcase
        return t;
    endfunction

    // master model configuration
    int cfg_fail_idx  = 15;
    int cfg_fail_code = 0;
    int cfg_fail_left = 0;
    bit cfg_stale     = 1'b0;

    bit nrst_prev = 1'b0;
    bit m_fail    = 1'b0;
    int m_cyc     = 0;
    int txn_count = 0;
    int hi_len    = 0;
    int last_hi_len = 0;

    // monitor + behavioural master, both on the inactive edge
    always @(negedge clk) begin
        txn_t e;
        int   idx;
        if (o_i2c_nrst && !nrst_prev) begin
            txn_count++;
            hi_len = 0;
            m_cyc  = 0;
            chk("i2c_addr", int'(o_i2c_addr), 'h1A);
            chk("read_not_write", int'(o_i2c_read_not_write), 0);
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_txn: got reg=%0d data=0x%0h, expected no transaction",
                         o_i2c_register, o_i2c_data);
            end else begin
                e = sb_q.pop_front();
                chk("txn_reg", int'(o_i2c_register), int'(e.rg));
                chk("txn_data", int'(o_i2c_data), int'(e.dat));
            end
            idx    = (o_i2c_register == 7'd15) ? 0 : int'(o_i2c_register) + 1;
            m_fail = (idx == cfg_fail_idx) && (cfg_fail_left > 0);
            if (m_fail) cfg_fail_left--;
        end
        if (!o_i2c_nrst) begin
            if (nrst_prev) last_hi_len = hi_len;
            m_cyc     = 0;
            i2c_done  = 1'b0;
            i2c_fault = cfg_stale ? 4'hF : 4'h0;
        end else begin
            hi_len++;
            m_cyc++;
            if (cfg_stale && m_cyc == 10) i2c_fault = 4'h0;
            if (m_cyc == 61) begin
                if (!m_fail)                 i2c_done  = 1'b1;
                else if (cfg_fail_code != 14) i2c_fault = 4'(cfg_fail_code);
            end
        end
        nrst_prev = o_i2c_nrst;
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_config_done"}, int'(o_config_done), 0);
        chk({tag, "_error"}, int'(o_error), 0);
        chk({tag, "_error_index"}, int'(o_error_index), 0);
        chk({tag, "_error_code"}, int'(o_error_code), 0);
        chk({tag, "_i2c_nrst"}, int'(o_i2c_nrst), 0);
        chk({tag, "_i2c_register"}, int'(o_i2c_register), 0);
        chk({tag, "_i2c_data"}, int'(o_i2c_data), 0);
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (!((o_config_done || o_error) && !o_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL %s_finish: got no completion within %0d cycles, expected done or error", tag, budget);
        end
    endtask

    // pushes the transaction order the bench expects from a row's fault settings
    task automatic push_expected(input int fidx, input int times);
        int n;
        for (int i = 0; i <= 10; i++) begin
            n = 1;
            if (i == fidx) n = (times > MAXR) ? MAXR + 1 : times + 1;
            for (int k = 0; k < n; k++) sb_q.push_back(spec_entry(i));
            if (i == fidx && times > MAXR) break;
        end
    endtask

    typedef struct {
        string name;
        int    fail_idx;
        int    fail_code;
        int    times;
        bit    stale;
        bit    exp_err;
        int    exp_idx;
        int    exp_code;
        int    exp_txns;
    } row_t;

    row_t rows[7];

    function automatic row_t mk(input string nm, input int fi, input int fc, input int tm, input bit st,
                                input bit ee, input int ei, input int ec, input int et);
        row_t r;
        r.name = nm; r.fail_idx = fi; r.fail_code = fc; r.times = tm; r.stale = st;
        r.exp_err = ee; r.exp_idx = ei; r.exp_code = ec; r.exp_txns = et;
        return r;
    endfunction

    initial begin
        i_nrst  = 1'b0;
        i_start = 1'b0;

        rows[0] = mk("clean",      15, 0, 0, 1'b0, 1'b0,  0, 0, 11);
        rows[1] = mk("fault_i3",    3, 2, 1, 1'b0, !RETRY, 3, 2, RETRY ? 12 : 4);
        rows[2] = mk("fault_i5x2",  5, 3, 2, 1'b0, !RETRY, 5, 3, RETRY ? 13 : 6);
        rows[3] = mk("timeout_i0",  0, 14, 1, 1'b0, !RETRY, 0, 14, RETRY ? 12 : 1);
        rows[4] = mk("stale_f",    15, 0, 0, 1'b1, 1'b0,  0, 0, 11);
        rows[5] = mk("fault_i10",  10, 5, 1, 1'b0, !RETRY, 10, 5, RETRY ? 12 : 11);
        rows[6] = mk("fault_i2x4",  2, 1, 4, 1'b0, 1'b1,  2, 1, RETRY ? 6 : 3);

        foreach (rows[r]) begin
            sb_q.delete();
            cfg_fail_idx  = rows[r].fail_idx;
            cfg_fail_code = rows[r].fail_code;
            cfg_fail_left = rows[r].times;
            cfg_stale     = rows[r].stale;
            i_nrst = 1'b0;
            repeat (3) @(negedge clk);
            check_reset_vals({rows[r].name, "_rst"});
            txn_count = 0;
            push_expected(rows[r].fail_idx, rows[r].times);
            i_nrst = 1'b1;
            wait_end(rows[r].name, 40000);
            repeat (300) @(negedge clk);
            chk({rows[r].name, "_config_done"}, int'(o_config_done), int'(!rows[r].exp_err));
            chk({rows[r].name, "_error"}, int'(o_error), int'(rows[r].exp_err));
            chk({rows[r].name, "_busy"}, int'(o_busy), 0);
            chk({rows[r].name, "_i2c_nrst"}, int'(o_i2c_nrst), 0);
            chk({rows[r].name, "_txns"}, txn_count, rows[r].exp_txns);
            chk({rows[r].name, "_sb_left"}, sb_q.size(), 0);
            if (rows[r].exp_err) begin
                chk({rows[r].name, "_error_index"}, int'(o_error_index), rows[r].exp_idx);
                chk({rows[r].name, "_error_code"}, int'(o_error_code), rows[r].exp_code);
                if (rows[r].exp_code == 14)
                    chk({rows[r].name, "_wait_len"}, last_hi_len, 1000);
            end
        end

        // reset in the middle of index 6's WAIT, then start-while-busy, then a fresh start from IDLE
        begin
            int n = 0;
            sb_q.delete();
            cfg_fail_idx = 15; cfg_fail_left = 0; cfg_stale = 1'b0;
            i_nrst = 1'b0;
            repeat (3) @(negedge clk);
            txn_count = 0;
            for (int i = 0; i <= 6; i++) sb_q.push_back(spec_entry(i));
            i_nrst = 1'b1;
            while (!(txn_count == 7 && o_i2c_nrst) && n < 5000) begin
                @(negedge clk);
                n++;
            end
            chk("midrst_reached_i6", txn_count, 7);
            repeat (20) @(negedge clk);
            chk("midrst_in_wait", int'(o_i2c_nrst), 1);
            i_nrst = 1'b0;
            #2;
            check_reset_vals("midrst_async");
            @(negedge clk);
            chk("midrst_sb_left", sb_q.size(), 0);
            txn_count = 0;
            push_expected(15, 0);
            i_nrst = 1'b1;
            repeat (200) @(negedge clk);
            chk("busy_before_start", int'(o_busy), 1);
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
            wait_end("restart", 40000);
            chk("restart_done", int'(o_config_done), 1);
            chk("restart_error", int'(o_error), 0);
            chk("restart_txns", txn_count, 11);
            chk("restart_sb_left", sb_q.size(), 0);

            txn_count = 0;
            push_expected(15, 0);
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
            repeat (2) @(negedge clk);
            chk("idle_start_busy", int'(o_busy), 1);
            chk("idle_start_done_cleared", int'(o_config_done), 0);
            wait_end("idle_start", 40000);
            chk("idle_start_done", int'(o_config_done), 1);
            chk("idle_start_txns", txn_count, 11);
            chk("idle_start_sb_left", sb_q.size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
